// File: rtl/my_pkg.sv
// my_pkg: shared port indices, packet width and XY route helper for the mesh router.
package my_pkg;
  localparam int LOCAL = 0;
  localparam int EAST = 1;
  localparam int NORTH = 2;
  localparam int WEST = 3;
  localparam int SOUTH = 4;
  localparam int PACKET_LENGTH = 16;
  localparam int COORD_MAX = 16;

  // Dimension-ordered routing: resolve X first, then Y; one-hot output request.
  function automatic logic [4:0] xy_route(input logic [COORD_MAX-1:0] dx, dy, x, y);
    return dx > x ? 5'(1 << EAST) :
           dx < x ? 5'(1 << WEST) :
           dy > y ? 5'(1 << NORTH) :
           dy < y ? 5'(1 << SOUTH) : 5'(1 << LOCAL);
  endfunction
endpackage

// File: rtl/router_fifo.sv
// router_fifo: power-of-two input FIFO with registered empty/full flags and occupancy count.
module router_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_d, wp_q, rp_d, rp_q;
  logic [CW-1:0] cnt_d, cnt_q;
  logic full_d, full_q, empty_d, empty_q, do_push, do_pop;
  always_comb begin
    do_push = push && !full_q;
    do_pop = pop && !empty_q;
    wp_d = wp_q + AW'(do_push);
    rp_d = rp_q + AW'(do_pop);
    cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    full_d = cnt_d == CW'(DEPTH);
    empty_d = cnt_d == '0;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      full_q <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      empty_q <= empty_d;
    end
  end
  // Storage needs no reset: the pointers and flags alone define what is valid.
  always_ff @(posedge clk) if (do_push) mem_q[wp_q] <= din;
  assign dout = mem_q[rp_q];
  assign empty = empty_q;
  assign count = cnt_q;
endmodule

// File: rtl/noc_router_buf.sv
// noc_router_buf: five-port buffered XY mesh router; input FIFOs, per-output
// round-robin arbitration and a registered valid/ready output stage.
module noc_router_buf
  import my_pkg::*;
#(
  parameter int PACKET_W   = PACKET_LENGTH,
  parameter int COORD_W    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int X_COORD    = 0,
  parameter int Y_COORD    = 0
) (
  input  logic                     clk,
  input  logic                     arst_n,
  input  logic [4:0][PACKET_W-1:0] in_data,
  input  logic [4:0]               in_valid,
  output logic [4:0]               in_ready,
  output logic [4:0][PACKET_W-1:0] out_data,
  output logic [4:0]               out_valid,
  input  logic [4:0]               out_ready,
  output logic                     conflict
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  logic [4:0][PACKET_W-1:0] head;
  logic [4:0][CW-1:0] cnt;
  logic [4:0][4:0] req, gnt;
  logic [4:0] empty, pop, load, multi;
  logic conflict_d, conflict_q;
  for (genvar i = 0; i < 5; i++) begin : g_in
    router_fifo #(.WIDTH(PACKET_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk(clk),
      .arst_n(arst_n),
      .push(in_valid[i] && in_ready[i]),
      .pop(pop[i]),
      .din(in_data[i]),
      .dout(head[i]),
      .empty(empty[i]),
      .count(cnt[i])
    );
    assign in_ready[i] = cnt[i] < CW'(FIFO_DEPTH);
    assign req[i] = empty[i] ? '0 : xy_route(COORD_MAX'(head[i][PACKET_W-1 -: COORD_W]),
                                             COORD_MAX'(head[i][PACKET_W-1-COORD_W -: COORD_W]),
                                             COORD_MAX'(X_COORD), COORD_MAX'(Y_COORD));
  end
  for (genvar o = 0; o < 5; o++) begin : g_out
    logic [4:0] r, g;
    logic [2:0] j, sel, ptr_d, ptr_q;
    logic vld_d, vld_q;
    logic [PACKET_W-1:0] dat_d, dat_q;
    always_comb begin
      for (int i = 0; i < 5; i++) r[i] = req[i][o];
      g = '0;
      j = '0;
      sel = '0;
      // Scan far-to-near so the requester closest after ptr_q is kept last.
      for (int k = 4; k >= 0; k--) begin
        j = 3'((int'(ptr_q) + 1 + k) % 5);
        if (r[j]) begin
          g = 5'(1 << j);
          sel = j;
        end
      end
      ptr_d = ptr_q;
      vld_d = vld_q && !out_ready[o];
      dat_d = dat_q;
      if (load[o]) {ptr_d, vld_d, dat_d} = {sel, 1'b1, head[sel]};
    end
    always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
        ptr_q <= 3'd4;
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        ptr_q <= ptr_d;
        vld_q <= vld_d;
        dat_q <= dat_d;
      end
    end
    assign load[o] = |r && (!vld_q || out_ready[o]);
    assign multi[o] = $countones(r) > 1;
    assign gnt[o] = g;
    assign out_valid[o] = vld_q;
    assign out_data[o] = dat_q;
  end
  always_comb begin
    pop = '0;
    for (int o = 0; o < 5; o++) pop |= load[o] ? gnt[o] : '0;
    conflict_d = |multi;
  end
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) conflict_q <= 1'b0;
    else conflict_q <= conflict_d;
  end
  assign conflict = conflict_q;
endmodule

// File: tb/tb_noc_router_buf.sv
// tb_noc_router_buf: directed and random stimulus for the router at node (1,1),
// checked against a queue-based transaction model of the routing rules.
module tb_noc_router_buf;
  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic [4:0][15:0] in_data = '0;
  logic [4:0] in_valid = '0;
  logic [4:0] in_ready;
  logic [4:0][15:0] out_data;
  logic [4:0] out_valid;
  logic [4:0] out_ready = 5'h1f;
  logic conflict;
  logic [4:0] acc;
  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] mq [5][$];
  bit mvld [5];
  logic [15:0] mdat [5];
  int mptr [5];
  bit mconf;

  noc_router_buf #(.PACKET_W(16), .COORD_W(4), .FIFO_DEPTH(4), .X_COORD(1), .Y_COORD(1)) dut (
    .clk(clk),
    .arst_n(arst_n),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int route(input logic [15:0] p);
    if (p[15:12] > 4'd1) return 1;
    if (p[15:12] < 4'd1) return 3;
    if (p[11:8] > 4'd1) return 2;
    if (p[11:8] < 4'd1) return 4;
    return 0;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 5; i++) begin
      mq[i].delete();
      mvld[i] = 0;
      mdat[i] = '0;
      mptr[i] = 4;
    end
    mconf = 0;
  endfunction

  task automatic model_step(output logic [4:0] a);
    int sz [5];
    logic [15:0] hd [5];
    bit c;
    c = 0;
    for (int i = 0; i < 5; i++) begin
      sz[i] = mq[i].size();
      hd[i] = '0;
      if (sz[i] > 0) hd[i] = mq[i][0];
    end
    for (int o = 0; o < 5; o++) begin
      int n, pick;
      n = 0;
      pick = -1;
      for (int k = 1; k <= 5; k++) begin
        int j;
        j = (mptr[o] + k) % 5;
        if (sz[j] > 0 && route(hd[j]) == o) begin
          n++;
          if (pick < 0) pick = j;
        end
      end
      if (n > 1) c = 1;
      if (pick >= 0 && (!mvld[o] || out_ready[o])) begin
        mdat[o] = mq[pick].pop_front();
        mvld[o] = 1;
        mptr[o] = pick;
      end else if (mvld[o] && out_ready[o]) mvld[o] = 0;
    end
    a = '0;
    for (int i = 0; i < 5; i++)
      if (in_valid[i] && sz[i] < 4) begin
        mq[i].push_back(in_data[i]);
        a[i] = 1'b1;
      end
    mconf = c;
  endtask

  task automatic compare_all();
    for (int o = 0; o < 5; o++) begin
      check($sformatf("out_valid[%0d]", o), 32'(out_valid[o]), 32'(mvld[o]));
      if (mvld[o]) check($sformatf("out_data[%0d]", o), 32'(out_data[o]), 32'(mdat[o]));
      check($sformatf("in_ready[%0d]", o), 32'(in_ready[o]), 32'(mq[o].size() < 4));
    end
    check("conflict", 32'(conflict), 32'(mconf));
  endtask

  task automatic cycle(output logic [4:0] a);
    @(posedge clk);
    model_step(a);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    logic [4:0] a;
    in_valid = '0;
    out_ready = 5'h1f;
    repeat (n) cycle(a);
  endtask

  initial begin
    logic [15:0] rx [$];
    int k;
    model_reset();
    repeat (3) @(posedge clk);
    #1 arst_n = 1'b1;
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_in_ready", 32'(in_ready), 32'h1f);
    check("rst_conflict", 32'(conflict), 32'h0);
    check("rst_out_data", 32'(out_data[1]), 32'h0);

    in_data[0] = 16'h31A5;
    in_valid = 5'b00001;
    cycle(acc);
    in_valid = '0;
    check("straight_early", 32'(out_valid), 32'h0);
    cycle(acc);
    check("straight_valid", 32'(out_valid), 32'h02);
    check("straight_data", 32'(out_data[1]), 32'h31A5);
    idle(3);

    in_data[2] = 16'h2102;
    in_data[3] = 16'h2103;
    in_data[4] = 16'h2104;
    in_valid = 5'b11100;
    cycle(acc);
    in_valid = '0;
    cycle(acc);
    check("cont_north", 32'(out_data[1]), 32'h2102);
    check("cont_conflict", 32'(conflict), 32'h1);
    cycle(acc);
    check("cont_west", 32'(out_data[1]), 32'h2103);
    cycle(acc);
    check("cont_south", 32'(out_data[1]), 32'h2104);
    check("cont_valid", 32'(out_valid), 32'h02);
    idle(3);

    out_ready = 5'b11101;
    in_valid = 5'b00001;
    k = 0;
    repeat (10) begin
      in_data[0] = 16'h3100 | 16'(k);
      cycle(acc);
      if (acc[0]) k++;
    end
    in_valid = '0;
    check("bp_accepted", 32'(k), 32'd5);
    check("bp_in_ready", 32'(in_ready[0]), 32'h0);
    check("bp_hold", 32'(out_data[1]), 32'h3100);
    out_ready = 5'h1f;
    for (int i = 1; i < 5; i++) begin
      cycle(acc);
      check("bp_drain", 32'(out_data[1]), 32'(16'h3100 | 16'(i)));
    end
    cycle(acc);
    check("bp_empty", 32'(out_valid[1]), 32'h0);
    idle(2);

    in_valid = 5'b00001;
    for (int i = 0; i < 23; i++) begin
      if (i == 20) in_valid = '0;
      in_data[0] = 16'h1100 | 16'(i);
      if (i < 20) check("stream_ready", 32'(in_ready[0]), 32'h1);
      cycle(acc);
      if (out_valid[0]) rx.push_back(out_data[0]);
    end
    check("stream_count", 32'(rx.size()), 32'd20);
    for (int i = 0; i < rx.size(); i++) check("stream_order", 32'(rx[i]), 32'(16'h1100 | 16'(i)));
    idle(2);

    repeat (400) begin
      in_valid = 5'($urandom);
      out_ready = 5'($urandom) | 5'($urandom);
      for (int i = 0; i < 5; i++)
        in_data[i] = {4'($urandom_range(0, 2)), 4'($urandom_range(0, 2)), 8'($urandom)};
      cycle(acc);
    end

    out_ready = '0;
    in_valid = 5'h1f;
    repeat (6) cycle(acc);
    #2 arst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1f);
    model_reset();
    in_valid = '0;
    repeat (2) @(posedge clk);
    #1 arst_n = 1'b1;
    idle(10);
    check("midrst_no_stale", 32'(out_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
